teclado_calculadora: RTL
========================

// Module: teclado_calculadora
// PURPOSE
//  Scans a 4x4 matrix keypad, synchronises and debounces the rows and emits one event per key press.
//  Produces the operator/equals interface consumed by the calculator operation FSM
//  (operando_en, que_operacion, igual_en) plus digit and clear events for the number-entry logic.
// PARAMETERS
//  SCAN_TICKS      250   clk cycles each column stays driven before rows are sampled (min 4)
//  DEBOUNCE_SCANS  20    consecutive identical samples needed to accept a press or a release (min 2)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  filas_n        in   4  keypad rows, active-low, pulled up, asynchronous
//  columnas_n     out  4  keypad column drive, active-low, one-hot-low
//  digito         out  4  value of last digit key (0-9), held until the next digit event
//  digito_en      out  1  1-cycle pulse: new digit on digito
//  operando_en    out  1  1-cycle pulse: operator or equals key accepted
//  que_operacion  out  2  1=suma, 2=resta, 3=igual; held until the next operator event
//  igual_en       out  1  1-cycle pulse, coincident with operando_en when que_operacion=3
//  borrar_en      out  1  1-cycle pulse: clear key accepted
//  tecla_activa   out  1  level: a key is accepted and not yet released (debug)
// BEHAVIOUR
//  Reset (clk edge with reset=1): state=SCAN, col index=0, columnas_n=4'b1110, tick/debounce counters=0.
//  Reset also clears every output: digito=0, que_operacion=0, all pulses=0, tecla_activa=0.
//  Reset mid-scan or mid-debounce drops any pending key; no event is emitted.
//  filas_n passes through a 2-FF synchroniser, and only the synchronised value (filas_s) is used.
//  The tick counter counts 0..SCAN_TICKS-1; filas_s is sampled when tick=SCAN_TICKS-1 (the sample point).
//  Key map [row][col], col0..3:
//   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
//   A=suma(1), B=resta(2), #=igual(3), C=borrar; * and D are ignored (no event, still debounced).
//  FSM:
//   SCAN     - at each sample point with filas_s=4'b1111: rotate to the next column, 3 wraps to 0
//              (1110->1101->1011->0111->1110).
//            - exactly one row low: latch row/col, clear the debounce count, go to DEBOUNCE
//              with the column held.
//            - two or more rows low: treat as no key.
//   DEBOUNCE - at each sample point, same single row low: count+1.
//            - pattern differs (including release or multi-row): return to SCAN and advance the column.
//            - count reaches DEBOUNCE_SCANS: go to EMIT.
//   EMIT     - one cycle; drives the pulse outputs combinationally from the state, registered into outputs:
//            - digit: digito<=value, digito_en=1.
//            - A/B: que_operacion<=1/2, operando_en=1.
//            - #: que_operacion<=3, operando_en=1, igual_en=1.
//            - C: borrar_en=1.
//            - Then go to RELEASE; tecla_activa<=1.
//   RELEASE  - column held.
//            - the debounce count increments at each sample point with filas_s=4'b1111 and clears on any low row.
//            - at DEBOUNCE_SCANS: tecla_activa<=0, advance the column, go to SCAN.
//  Holding a key yields exactly one event (no auto-repeat).
//  A second key pressed while in RELEASE is ignored until all keys are released.
//  Latency, physical edge to pulse: 2 sync cycles + up to (DEBOUNCE_SCANS+1)*SCAN_TICKS + the
//  4-column scan time + 1 EMIT cycle.
//  All pulses are registered and exactly one clk wide. At most one of digito_en/operando_en/borrar_en
//  is high in any cycle.
// TESTING (SCAN_TICKS=4, DEBOUNCE_SCANS=3; keypad model drives filas_n from columnas_n)
//  1. Idle, no key -> columnas_n cycles 1110,1101,1011,0111,1110 every 4 clk; no pulses.
//  2. Hold '7' (r2,c0) 100 clk -> exactly one digito_en with digito=7; tecla_activa=1 until
//     3 clean samples after release.
//  3. Press '+', release, press '#' -> first operando_en with que_operacion=1, igual_en=0;
//     then operando_en=1 and igual_en=1 in the same cycle with que_operacion=3.
//  4. Bounce '5': toggle the row every 6 clk for 40 clk, then hold -> no event during
//     bouncing, one digito_en with digito=5 after settling.
//  5. '1' and '4' held together (c0, r0+r1 low) -> no event; release '4' -> one digito_en with digito=1.
//  6. reset=1 for 1 cycle while in DEBOUNCE on 'C' -> no borrar_en; outputs all 0;
//     columnas_n=1110 next cycle.

Source files
------------

// File: rtl/teclado_calculadora.sv
// 4x4 matrix keypad scanner for the calculator: synchronises and debounces the rows,
// then emits one digit/operator/equals/clear event per key press.
module teclado_calculadora #(
    parameter int unsigned SCAN_TICKS     = 250,
    parameter int unsigned DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] filas_n,
    output logic [3:0] columnas_n,
    output logic [3:0] digito,
    output logic       digito_en,
    output logic       operando_en,
    output logic [1:0] que_operacion,
    output logic       igual_en,
    output logic       borrar_en,
    output logic       tecla_activa
);
    localparam int unsigned TW = $clog2(SCAN_TICKS);
    localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    filas_m_q, filas_s_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    columnas_n_q, columnas_n_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [3:0]    fila_q, fila_d;
    logic [3:0]    digito_q, digito_d;
    logic [1:0]    que_operacion_q, que_operacion_d;
    logic          digito_en_q, digito_en_d;
    logic          operando_en_q, operando_en_d;
    logic          igual_en_q, igual_en_d;
    logic          borrar_en_q, borrar_en_d;
    logic          tecla_activa_q, tecla_activa_d;

    logic          sample;
    logic          one_low;
    logic          cnt_done;
    logic [3:0]    lows;
    logic [1:0]    fila_idx;
    logic [DW-1:0] cnt_inc;

    always_comb begin
        sample   = (tick_q == TW'(SCAN_TICKS - 1));
        tick_d   = sample ? '0 : tick_q + 1'b1;
        lows     = ~filas_s_q;
        one_low  = (lows != 4'd0) && ((lows & (lows - 4'd1)) == 4'd0);
        cnt_inc  = cnt_q + 1'b1;
        cnt_done = (cnt_inc == DW'(DEBOUNCE_SCANS));

        unique case (fila_q)
            4'b1110: fila_idx = 2'd0;
            4'b1101: fila_idx = 2'd1;
            4'b1011: fila_idx = 2'd2;
            default: fila_idx = 2'd3;
        endcase

        state_d         = state_q;
        col_d           = col_q;
        cnt_d           = cnt_q;
        fila_d          = fila_q;
        digito_d        = digito_q;
        que_operacion_d = que_operacion_q;
        tecla_activa_d  = tecla_activa_q;
        digito_en_d     = 1'b0;
        operando_en_d   = 1'b0;
        igual_en_d      = 1'b0;
        borrar_en_d     = 1'b0;

        unique case (state_q)
            SCAN: begin
                if (sample) begin
                    if (one_low) begin
                        fila_d  = filas_s_q;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (filas_s_q == fila_q) begin
                        if (cnt_done) begin
                            cnt_d   = '0;
                            state_d = EMIT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end
                end
            end
            EMIT: begin
                // Map [row][col]: * (r3c0) and D (r3c3) fall through to no event.
                unique case ({fila_idx, col_q})
                    4'h0: begin digito_d = 4'd1; digito_en_d = 1'b1; end
                    4'h1: begin digito_d = 4'd2; digito_en_d = 1'b1; end
                    4'h2: begin digito_d = 4'd3; digito_en_d = 1'b1; end
                    4'h4: begin digito_d = 4'd4; digito_en_d = 1'b1; end
                    4'h5: begin digito_d = 4'd5; digito_en_d = 1'b1; end
                    4'h6: begin digito_d = 4'd6; digito_en_d = 1'b1; end
                    4'h8: begin digito_d = 4'd7; digito_en_d = 1'b1; end
                    4'h9: begin digito_d = 4'd8; digito_en_d = 1'b1; end
                    4'hA: begin digito_d = 4'd9; digito_en_d = 1'b1; end
                    4'hD: begin digito_d = 4'd0; digito_en_d = 1'b1; end
                    4'h3: begin que_operacion_d = 2'd1; operando_en_d = 1'b1; end
                    4'h7: begin que_operacion_d = 2'd2; operando_en_d = 1'b1; end
                    4'hE: begin que_operacion_d = 2'd3; operando_en_d = 1'b1; igual_en_d = 1'b1; end
                    4'hB: borrar_en_d = 1'b1;
                    default: ;
                endcase
                tecla_activa_d = 1'b1;
                cnt_d          = '0;
                state_d        = RELEASE;
            end
            RELEASE: begin
                if (sample) begin
                    if (filas_s_q == 4'b1111) begin
                        if (cnt_done) begin
                            cnt_d          = '0;
                            tecla_activa_d = 1'b0;
                            col_d          = col_q + 2'd1;
                            state_d        = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        columnas_n_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= SCAN;
            filas_m_q       <= '1;
            filas_s_q       <= '1;
            tick_q          <= '0;
            col_q           <= '0;
            columnas_n_q    <= 4'b1110;
            cnt_q           <= '0;
            fila_q          <= '1;
            digito_q        <= '0;
            que_operacion_q <= '0;
            digito_en_q     <= 1'b0;
            operando_en_q   <= 1'b0;
            igual_en_q      <= 1'b0;
            borrar_en_q     <= 1'b0;
            tecla_activa_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            filas_m_q       <= filas_n;
            filas_s_q       <= filas_m_q;
            tick_q          <= tick_d;
            col_q           <= col_d;
            columnas_n_q    <= columnas_n_d;
            cnt_q           <= cnt_d;
            fila_q          <= fila_d;
            digito_q        <= digito_d;
            que_operacion_q <= que_operacion_d;
            digito_en_q     <= digito_en_d;
            operando_en_q   <= operando_en_d;
            igual_en_q      <= igual_en_d;
            borrar_en_q     <= borrar_en_d;
            tecla_activa_q  <= tecla_activa_d;
        end
    end

    assign columnas_n    = columnas_n_q;
    assign digito        = digito_q;
    assign digito_en     = digito_en_q;
    assign operando_en   = operando_en_q;
    assign que_operacion = que_operacion_q;
    assign igual_en      = igual_en_q;
    assign borrar_en     = borrar_en_q;
    assign tecla_activa  = tecla_activa_q;
endmodule
